// File: rtl/uart_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_BAUD_DIV = 16;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate divider: counts 0..BAUD_DIV-1 and flags the last cycle of each bit period.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap on the last cycle of a bit, restart on clear.
    always_comb begin
        tick  = (cnt_q == CW'(BAUD_DIV - 1));
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from a show-ahead sync FIFO.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tick;
    logic                  baud_clr;
    logic                  last_stop;
    logic                  pop;

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .tick  (tick)
    );

    // Frame sequencing, pop decision and next values of the registered line outputs.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;

        last_stop = (state_q == STOP) && tick && ((STOP_BITS == 1) || stop_cnt_q);
        pop       = enable && !fifo_empty && ((state_q == IDLE) || last_stop);

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop overrides the normal exit from IDLE or the final stop cycle.
        if (pop) begin
            state_d  = START;
            shift_d  = fifo_rd_data;
            parity_d = (^fifo_rd_data) ^ (PARITY_ODD != 0);
        end

        baud_clr = (state_d != state_q) || (state_q == IDLE);

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = last_stop;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign fifo_rd_en = pop;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: plain 8N1 instance on a FIFO model, plus 8E2 and 8O1 instances on a one-word holder.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    // Instance 0: BAUD_DIV=4, no parity, one stop bit, fed by an 8-deep FIFO model.
    logic       en0 = 1'b0;
    logic       empty0, rd_en0, tx0, busy0, done0;
    logic [7:0] rdata0;
    logic [7:0] fmem [0:7];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic       push_req = 1'b0;
    logic [7:0] push_data = 8'h00;

    always @(posedge clk) begin
        if (push_req) begin
            fmem[wr_ptr[2:0]] <= push_data;
            wr_ptr <= wr_ptr + 1;
        end
        if (rd_en0) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    assign empty0 = (wr_ptr == rd_ptr);
    assign rdata0 = fmem[rd_ptr[2:0]];

    // Instances 1 (even parity, two stop bits) and 2 (odd parity, one stop bit) share a one-word holder.
    logic       en12 = 1'b0;
    logic       hold_load = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       hold_v = 1'b0;
    logic [7:0] hold_q = 8'h00;
    logic       empty12;
    logic       rd_en1, tx1, busy1, done1;
    logic       rd_en2, tx2, busy2, done2;

    always @(posedge clk) begin
        if (hold_load) begin
            hold_v <= 1'b1;
            hold_q <= hold_data;
        end else if (rd_en1 || rd_en2) begin
            hold_v <= 1'b0;
        end
    end

    assign empty12 = !hold_v;

    fifo_uart_tx #(
        .DATA_WIDTH (8), .BAUD_DIV (4), .PARITY_EN (0), .PARITY_ODD (0), .STOP_BITS (1)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .enable (en0), .fifo_empty (empty0),
        .fifo_rd_data (rdata0), .fifo_rd_en (rd_en0), .tx (tx0), .busy (busy0), .tx_done (done0)
    );

    fifo_uart_tx #(
        .DATA_WIDTH (8), .BAUD_DIV (4), .PARITY_EN (1), .PARITY_ODD (0), .STOP_BITS (2)
    ) dut1 (
        .clk (clk), .rst_n (rst_n), .enable (en12), .fifo_empty (empty12),
        .fifo_rd_data (hold_q), .fifo_rd_en (rd_en1), .tx (tx1), .busy (busy1), .tx_done (done1)
    );

    fifo_uart_tx #(
        .DATA_WIDTH (8), .BAUD_DIV (4), .PARITY_EN (1), .PARITY_ODD (1), .STOP_BITS (1)
    ) dut2 (
        .clk (clk), .rst_n (rst_n), .enable (en12), .fifo_empty (empty12),
        .fifo_rd_data (hold_q), .fifo_rd_en (rd_en2), .tx (tx2), .busy (busy2), .tx_done (done2)
    );

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Queue one word into the FIFO model.
    task automatic push(input logic [7:0] b);
        push_req  = 1'b1;
        push_data = b;
        cyc();
        push_req  = 1'b0;
    endtask

    // Bit idx of an 8N1 frame carrying b: start, data LSB first, stop.
    function automatic logic fbit(input logic [7:0] b, input int idx);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[idx];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en0   = 1'b0;
        en12  = 1'b0;
        repeat (3) cyc();
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || rd_en0 !== 1'b0)
            $display("FAIL reset0 tx=%b busy=%b done=%b rd_en=%b expected 1 0 0 0", tx0, busy0, done0, rd_en0);
        checks++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0)
            $display("FAIL reset12 tx1=%b busy1=%b tx2=%b busy2=%b expected 1 0 1 0", tx1, busy1, tx2, busy2);
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || rd_en0 !== 1'b0) errors++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0 || tx2 !== 1'b1 || busy2 !== 1'b0) errors++;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_frame();
        int   pops;
        logic exp_tx, exp_busy, exp_done;
        pops = 0;
        push(8'hA5);
        en0 = 1'b1;
        #1;
        checks++;
        if (rd_en0 !== 1'b1) begin
            errors++;
            $display("FAIL single_pop0 rd_en=%b expected 1", rd_en0);
        end
        for (int c = 1; c <= 41; c++) begin
            cyc();
            if (rd_en0 === 1'b1) pops++;
            exp_tx   = (c <= 40) ? fbit(8'hA5, (c - 1) / 4) : 1'b1;
            exp_busy = (c <= 40);
            exp_done = (c == 41);
            checks++;
            if (tx0 !== exp_tx || busy0 !== exp_busy || done0 !== exp_done) begin
                errors++;
                $display("FAIL single c=%0d tx=%b/%b busy=%b/%b done=%b/%b (got/expected)",
                         c, tx0, exp_tx, busy0, exp_busy, done0, exp_done);
            end
        end
        checks++;
        if (pops != 0) begin
            errors++;
            $display("FAIL single_extra_pops got %0d expected 0", pops);
        end
        en0 = 1'b0;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic       exp_tx, exp_busy, exp_done, exp_rd;
        push(8'h3C);
        push(8'hC3);
        en0 = 1'b1;
        #1;
        checks++;
        if (rd_en0 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop0 rd_en=%b expected 1", rd_en0);
        end
        for (int c = 1; c <= 81; c++) begin
            cyc();
            b        = (c <= 40) ? 8'h3C : 8'hC3;
            exp_tx   = (c <= 80) ? fbit(b, ((c - 1) / 4) % 10) : 1'b1;
            exp_busy = (c <= 80);
            exp_done = (c == 41) || (c == 81);
            exp_rd   = (c == 40);
            checks++;
            if (tx0 !== exp_tx || busy0 !== exp_busy || done0 !== exp_done || rd_en0 !== exp_rd) begin
                errors++;
                $display("FAIL b2b c=%0d tx=%b/%b busy=%b/%b done=%b/%b rd_en=%b/%b (got/expected)",
                         c, tx0, exp_tx, busy0, exp_busy, done0, exp_done, rd_en0, exp_rd);
            end
        end
        en0 = 1'b0;
        cyc();
    endtask

    task automatic test_parity_stop();
        logic [11:0] f1;
        logic [10:0] f2;
        logic        e_tx1, e_busy1, e_done1, e_tx2, e_busy2, e_done2;
        f1 = {2'b11, 1'b1, 8'h07, 1'b0};
        f2 = {1'b1, 1'b0, 8'h07, 1'b0};
        hold_data = 8'h07;
        hold_load = 1'b1;
        cyc();
        hold_load = 1'b0;
        en12 = 1'b1;
        #1;
        checks++;
        if (rd_en1 !== 1'b1 || rd_en2 !== 1'b1) begin
            errors++;
            $display("FAIL parity_pop0 rd_en1=%b rd_en2=%b expected 1 1", rd_en1, rd_en2);
        end
        for (int c = 1; c <= 49; c++) begin
            cyc();
            e_tx1   = (c <= 48) ? f1[(c - 1) / 4] : 1'b1;
            e_busy1 = (c <= 48);
            e_done1 = (c == 49);
            e_tx2   = (c <= 44) ? f2[(c - 1) / 4] : 1'b1;
            e_busy2 = (c <= 44);
            e_done2 = (c == 45);
            checks++;
            if (tx1 !== e_tx1 || busy1 !== e_busy1 || done1 !== e_done1 || rd_en1 !== 1'b0) begin
                errors++;
                $display("FAIL even_2stop c=%0d tx=%b/%b busy=%b/%b done=%b/%b rd_en=%b/0 (got/expected)",
                         c, tx1, e_tx1, busy1, e_busy1, done1, e_done1, rd_en1);
            end
            checks++;
            if (tx2 !== e_tx2 || busy2 !== e_busy2 || done2 !== e_done2 || rd_en2 !== 1'b0) begin
                errors++;
                $display("FAIL odd_1stop c=%0d tx=%b/%b busy=%b/%b done=%b/%b rd_en=%b/0 (got/expected)",
                         c, tx2, e_tx2, busy2, e_busy2, done2, e_done2, rd_en2);
            end
        end
        en12 = 1'b0;
        cyc();
    endtask

    task automatic test_empty();
        int bad;
        bad = 0;
        en0 = 1'b1;
        for (int c = 0; c < 100; c++) begin
            cyc();
            if (rd_en0 !== 1'b0 || tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL empty_idle bad_cycles=%0d expected 0", bad);
        end
        en0 = 1'b0;
        cyc();
    endtask

    task automatic test_enable_drop();
        logic exp_tx, exp_busy, exp_done;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        en0 = 1'b1;
        #1;
        checks++;
        if (rd_en0 !== 1'b1) begin
            errors++;
            $display("FAIL drop_pop0 rd_en=%b expected 1", rd_en0);
        end
        for (int c = 1; c <= 48; c++) begin
            cyc();
            exp_tx   = (c <= 40) ? fbit(8'h11, (c - 1) / 4) : 1'b1;
            exp_busy = (c <= 40);
            exp_done = (c == 41);
            checks++;
            if (tx0 !== exp_tx || busy0 !== exp_busy || done0 !== exp_done || rd_en0 !== 1'b0) begin
                errors++;
                $display("FAIL drop c=%0d tx=%b/%b busy=%b/%b done=%b/%b rd_en=%b/0 (got/expected)",
                         c, tx0, exp_tx, busy0, exp_busy, done0, exp_done, rd_en0);
            end
            if (c == 10) en0 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic exp_tx, exp_busy, exp_done;
        en0 = 1'b1;
        #1;
        checks++;
        if (rd_en0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pop0 rd_en=%b expected 1", rd_en0);
        end
        for (int c = 1; c <= 18; c++) begin
            cyc();
            exp_tx = fbit(8'h22, (c - 1) / 4);
            checks++;
            if (tx0 !== exp_tx || busy0 !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_pre c=%0d tx=%b/%b busy=%b/1 (got/expected)", c, tx0, exp_tx, busy0);
            end
        end
        en0   = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async tx=%b busy=%b done=%b expected 1 0 0", tx0, busy0, done0);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        en0 = 1'b1;
        #1;
        checks++;
        if (rd_en0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_repop rd_en=%b expected 1", rd_en0);
        end
        for (int c = 1; c <= 41; c++) begin
            cyc();
            exp_tx   = (c <= 40) ? fbit(8'h33, (c - 1) / 4) : 1'b1;
            exp_busy = (c <= 40);
            exp_done = (c == 41);
            checks++;
            if (tx0 !== exp_tx || busy0 !== exp_busy || done0 !== exp_done || rd_en0 !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_post c=%0d tx=%b/%b busy=%b/%b done=%b/%b rd_en=%b/0 (got/expected)",
                         c, tx0, exp_tx, busy0, exp_busy, done0, exp_done, rd_en0);
            end
        end
        en0 = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_parity_stop();
        test_empty();
        test_enable_drop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
